vga_sync_ctrl: RTL and testbench
================================

Name: vga_sync_ctrl

Overview:
Timing controller for the VGA path. Divides the system clock down to the pixel rate with an internal divide-by-DIV counter. Sequences horizontal and vertical pixel counters and generates hsync, vsync, video_on and frame_start for the pixel generator and the output pins. Sits between the board clock and the colour/pixel logic and is the single timing master for the display.

Parameters:
DIV, 4, system clocks per pixel (≥2); 100 MHz / 4 = 25 MHz pixel rate
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800
V_VIS, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
CW, 10, width of px_x/px_y; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  run enable; 0 freezes all counters and outputs
pix_tick  out  1  one-clk pulse, once per pixel period
px_x  out  CW  horizontal counter, 0..H_TOTAL-1
px_y  out  CW  vertical counter, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
video_on  out  1  1 while the pixel is inside the visible area
frame_start  out  1  one-clk pulse marking the last pixel of each frame

Behaviour:
- Reset (async, any time including mid-frame): div_cnt=0, px_x=0, px_y=0, pix_tick=0, frame_start=0, hsync=vsync=!SYNC_POL (inactive), video_on=0. Every output takes its reset value immediately, not at the next edge.
- Divider: with en=1, div_cnt counts 0..DIV-1 and wraps. pix_tick=1 in the cycle where div_cnt==DIV-1 and en=1, otherwise 0.
- First pix_tick after reset release: at the DIV-th enabled clk.
- Counters update only on clk edges where pix_tick=1:
  - px_x increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, px_y increments and wraps V_TOTAL-1 -> 0.
  - px_x and px_y update in the same edge.
- hsync, vsync and video_on are registered decodes of px_x/px_y. They lag px_x/px_y by exactly one clk and are updated every enabled clk.
  - hsync active iff H_VIS+H_FP ≤ px_x ≤ H_VIS+H_FP+H_SYNC-1 (656..751).
  - vsync active iff V_VIS+V_FP ≤ px_y ≤ V_VIS+V_FP+V_SYNC-1 (490..491).
  - video_on = (px_x < H_VIS) && (px_y < V_VIS).
  - First enabled clk after reset: video_on becomes 1, since (0,0) is visible.
- frame_start=1 for exactly one clk: the cycle where pix_tick=1, px_x=H_TOTAL-1 and px_y=V_TOTAL-1. It is combinational with pix_tick, not lagged.
- en=0: div_cnt, px_x, px_y, hsync, vsync and video_on all hold; pix_tick=0 and frame_start=0. When en returns to 1, counting resumes from the held div_cnt with no skipped or duplicated pixel.
- en and rst together: rst wins.
- Counters never exceed TOTAL-1. The wrap comparison is equality on the registered value, with no overflow into bit CW.
- Timing per period (defaults):
  - line = H_TOTAL*DIV = 3200 clk
  - frame = 1,680,000 clk

Test Plan:
- Reset: rst pulsed high mid-line (px_x=300, px_y=100) → same-instant px_x=0, px_y=0, hsync=1, vsync=1, video_on=0, pix_tick=0. Release with en=1 → video_on=1 after 1 clk; first pix_tick at 4th clk; px_x=1 after it.
- Divider: en=1 for 40 clks → pix_tick high on clks 4, 8, …, 40, exactly 10 pulses, each 1 clk wide; px_x=10.
- hsync: run until px_x goes 655→656 → hsync falls 1 clk later. It stays low 384 clk (96 pixels) and rises 1 clk after px_x reaches 752. video_on falls 1 clk after px_x reaches 640 and returns 1 clk after px_x wraps to 0.
- Line/frame wrap: at px_x=799, px_y=489, a pix_tick → px_x=0 and px_y=490 on the same edge. vsync falls 1 clk later, stays low 6400 clk and rises 1 clk after px_y=492. At (799,524) a pix_tick → frame_start=1 for exactly one clk and counters go to (0,0). Exactly one frame_start per 1,680,000 clk.
- Enable stall: en=0 for 7 clks when div_cnt=2, px_x=100 → no pix_tick and all outputs constant during the stall. After en=1, the next pix_tick comes 1 enabled clk later and px_x=101.
- Non-default: DIV=2, H_TOTAL=10 (H_VIS=4, H_FP=1, H_SYNC=2, H_BP=3), V_TOTAL=6 (V_VIS=3, V_FP=1, V_SYNC=1, V_BP=1), SYNC_POL=1 → line = 20 clk, frame = 120 clk. hsync high (active) for px_x 5..6, vsync high (active) for px_y 4, one frame_start per 120 clk.

Source files
------------

// File: rtl/vga_sync_if.sv
// VGA timing bundle: run enable in, pixel counters and sync/blank strobes out.
// master = timing controller, slave = pixel generator / output pins.
interface vga_sync_if #(
  parameter int CW = 10
);
  logic          en;
  logic          pix_tick;
  logic [CW-1:0] px_x;
  logic [CW-1:0] px_y;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          frame_start;

  modport master (
    input  en,
    output pix_tick, px_x, px_y,
    output hsync, vsync, video_on,
    output frame_start
  );

  modport slave (
    output en,
    input  pix_tick, px_x, px_y,
    input  hsync, vsync, video_on,
    input  frame_start
  );
endinterface

// File: rtl/vga_sync_ctrl.sv
// VGA timing master: clk/DIV pixel divider, x/y counters, registered syncs.
// Ports: clk, rst (async high), bus (vga_sync_if.master: en in, timing out).
module vga_sync_ctrl #(
  parameter int DIV      = 4,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic      clk,
  input  logic      rst,
  vga_sync_if.master bus
);
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VEND   = CW'(H_VIS);
  localparam logic [CW-1:0] V_VEND   = CW'(V_VIS);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_VIS + V_FP + V_SYNC - 1);

  logic [DW-1:0] r_div_cnt;
  logic [CW-1:0] r_px_x;
  logic [CW-1:0] r_px_y;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;

  logic w_tick;
  logic w_h_last;
  logic w_v_last;
  logic w_hs_act;
  logic w_vs_act;
  logic w_vis;

  assign w_tick   = bus.en && (r_div_cnt == DIV_LAST);
  assign w_h_last = (r_px_x == H_LAST);
  assign w_v_last = (r_px_y == V_LAST);
  assign w_hs_act = (r_px_x >= HS_BEG) && (r_px_x <= HS_END);
  assign w_vs_act = (r_px_y >= VS_BEG) && (r_px_y <= VS_END);
  assign w_vis    = (r_px_x < H_VEND) && (r_px_y < V_VEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (bus.en) begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  // y advances on the same tick that wraps x
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px_x <= '0;
      r_px_y <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_px_x <= '0;
        r_px_y <= w_v_last ? '0 : r_px_y + 1'b1;
      end else begin
        r_px_x <= r_px_x + 1'b1;
      end
    end
  end

  // decodes of the current counters, so they trail px_x/px_y by one clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
      r_video_on <= 1'b0;
    end else if (bus.en) begin
      r_hsync    <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync    <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on <= w_vis;
    end
  end

  assign bus.pix_tick    = w_tick;
  assign bus.px_x        = r_px_x;
  assign bus.px_y        = r_px_y;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.video_on    = r_video_on;
  assign bus.frame_start = w_tick && w_h_last && w_v_last;
endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Directed bench for vga_sync_ctrl: default 640x480 timing and a tiny
// DIV=2 10x6 active-high configuration used for full-frame checks.
module tb_vga_sync_ctrl;
  logic clk;
  logic rst;
  logic rst2;
  int   checks;
  int   failures;

  vga_sync_if #(.CW(10)) b  ();
  vga_sync_if #(.CW(10)) b2 ();

  vga_sync_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b.master)
  );

  vga_sync_ctrl #(
    .DIV(2), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .CW(10)
  ) u_small (
    .clk (clk),
    .rst (rst2),
    .bus (b2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int ticks;
    int fs_cnt;
    int xp;
    int xq;
    int yp;
    int yq;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rst2     = 1'b1;
    b.en     = 1'b0;
    b2.en    = 1'b0;

    // reset state
    cyc(2);
    chk("rst_x", b.px_x, 0);
    chk("rst_y", b.px_y, 0);
    chk("rst_hs", b.hsync, 1);
    chk("rst_vs", b.vsync, 1);
    chk("rst_vid", b.video_on, 0);
    chk("rst_tick", b.pix_tick, 0);
    chk("rst_fs", b.frame_start, 0);

    // release, 40 enabled clks: ticks on clks 4,8,..,40
    rst  = 1'b0;
    b.en = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 40; i++) begin
      chk("div_tick", b.pix_tick, (i % 4 == 0) ? 1 : 0);
      if (i <= 2) chk("rel_vid", b.video_on, (i == 2) ? 1 : 0);
      if (i == 5) chk("first_x", b.px_x, 1);
      if (b.pix_tick) ticks++;
      cyc(1);
    end
    chk("div_cnt10", ticks, 10);
    chk("div_x10", b.px_x, 10);

    // stall at div_cnt=2, px_x=100
    cyc(362);
    chk("pre_stall_x", b.px_x, 100);
    b.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("stall_tick", b.pix_tick, 0);
      chk("stall_x", b.px_x, 100);
      chk("stall_hs", b.hsync, 1);
      chk("stall_vid", b.video_on, 1);
      chk("stall_fs", b.frame_start, 0);
      cyc(1);
    end
    b.en = 1'b1;
    chk("resume0_tick", b.pix_tick, 0);
    cyc(1);
    chk("resume1_tick", b.pix_tick, 1);
    chk("resume1_x", b.px_x, 100);
    cyc(1);
    chk("resume2_x", b.px_x, 101);
    chk("resume2_tick", b.pix_tick, 0);

    // asynchronous reset mid-line
    cyc(796);
    chk("mid_x", b.px_x, 300);
    chk("mid_vid", b.video_on, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_x", b.px_x, 0);
    chk("arst_y", b.px_y, 0);
    chk("arst_hs", b.hsync, 1);
    chk("arst_vs", b.vsync, 1);
    chk("arst_vid", b.video_on, 0);
    chk("arst_tick", b.pix_tick, 0);
    @(negedge clk);
    rst = 1'b0;

    // one full line plus a few clks: hsync, video_on, line wrap
    for (int n = 0; n <= 3204; n++) begin
      xp = (n / 4) % 800;
      yp = n / 3200;
      chk("line_x", b.px_x, xp);
      chk("line_y", b.px_y, yp);
      if (n == 0) begin
        chk("line_hs", b.hsync, 1);
        chk("line_vid", b.video_on, 0);
      end else begin
        xq = ((n - 1) / 4) % 800;
        chk("line_hs", b.hsync, (xq >= 656 && xq <= 751) ? 0 : 1);
        chk("line_vid", b.video_on, (xq < 640) ? 1 : 0);
      end
      chk("line_vs", b.vsync, 1);
      chk("line_fs", b.frame_start, 0);
      cyc(1);
    end

    // small config: rst wins over en
    b2.en = 1'b1;
    cyc(3);
    chk("s_rstwin_x", b2.px_x, 0);
    chk("s_rstwin_tick", b2.pix_tick, 0);
    chk("s_rstwin_hs", b2.hsync, 0);
    rst2 = 1'b0;

    // three frames of 120 clks
    fs_cnt = 0;
    for (int n = 0; n <= 365; n++) begin
      xp = (n / 2) % 10;
      yp = (n / 20) % 6;
      chk("s_x", b2.px_x, xp);
      chk("s_y", b2.px_y, yp);
      chk("s_tick", b2.pix_tick, (n % 2 == 1) ? 1 : 0);
      chk("s_fs", b2.frame_start, (n % 120 == 119) ? 1 : 0);
      if (n == 0) begin
        chk("s_hs", b2.hsync, 0);
        chk("s_vs", b2.vsync, 0);
        chk("s_vid", b2.video_on, 0);
      end else begin
        xq = ((n - 1) / 2) % 10;
        yq = ((n - 1) / 20) % 6;
        chk("s_hs", b2.hsync, (xq >= 5 && xq <= 6) ? 1 : 0);
        chk("s_vs", b2.vsync, (yq == 4) ? 1 : 0);
        chk("s_vid", b2.video_on, (xq < 4 && yq < 3) ? 1 : 0);
      end
      if (b2.frame_start) fs_cnt++;
      cyc(1);
    end
    chk("s_fs_count", fs_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
